// File: rtl/dmem_stall_ctrl.sv
// MEM-stage data-memory controller: direct-mapped write-through cache with pipeline stall.
// Optional hit/miss/stall counters are built when DMEM_STATS_EN is defined.
module dmem_stall_ctrl #(
    parameter int INDEX_W = 5,
    parameter int TAG_W   = 25
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rd_i,
    input  logic        wr_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
`ifdef DMEM_STATS_EN
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o,
    output logic [31:0] stall_cnt_o,
`endif
    output logic [1:0]  state_o
);
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_MEM, DONE} state_t;

    state_t             state_q, state_d;
    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [31:0]        data_mem [LINES];
    logic [31:0]        fill_q;
    logic               last_rd_q;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               hit, is_wr, is_rd;
    logic               unused_addr_bits;

    assign idx              = addr_i[INDEX_W+1:2];
    assign tag              = addr_i[31:INDEX_W+2];
    assign hit              = valid_q[idx] && (tag_mem[idx] == tag);
    assign is_wr            = wr_i;
    assign is_rd            = rd_i & ~wr_i;
    assign unused_addr_bits = ^addr_i[1:0];
    assign state_o          = state_q;

    // External handshake: mem_req_o rises with address/data/we stable and holds
    // until the one-cycle mem_ack_i pulse, which completes the transfer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        rdata_o = 32'h0;
        case (state_q)
            IDLE: begin
                if (is_wr) begin
                    stall_o = 1'b1;
                    state_d = WR_MEM;
                end else if (is_rd) begin
                    if (hit) begin
                        rdata_o = data_mem[idx];
                    end else begin
                        stall_o = 1'b1;
                        state_d = RD_MISS;
                    end
                end
            end
            RD_MISS, WR_MEM: begin
                stall_o = 1'b1;
                if (mem_ack_i) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                rdata_o = last_rd_q ? fill_q : 32'h0;
            end
            default: state_d = IDLE;
        endcase
        // Reset silences the pipeline-facing outputs immediately.
        if (rst_i) begin
            stall_o = 1'b0;
            rdata_o = 32'h0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'h0;
            mem_wdata_o <= 32'h0;
            fill_q      <= 32'h0;
            last_rd_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_wr) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= {addr_i[31:2], 2'b00};
                        mem_wdata_o <= wdata_i;
                        last_rd_q   <= 1'b0;
                    end else if (is_rd && !hit) begin
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= {addr_i[31:2], 2'b00};
                        last_rd_q  <= 1'b1;
                    end
                end
                RD_MISS: begin
                    if (mem_ack_i) begin
                        mem_req_o    <= 1'b0;
                        fill_q       <= mem_rdata_i;
                        valid_q[idx] <= 1'b1;
                    end
                end
                WR_MEM: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line storage needs no reset; the valid bits qualify it.
    always_ff @(posedge clk_i) begin
        if (state_q == RD_MISS && mem_ack_i && !rst_i) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= mem_rdata_i;
        end else if (state_q == WR_MEM && mem_ack_i && hit && !rst_i) begin
            data_mem[idx] <= wdata_i;
        end
    end

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_o   <= 32'h0;
            miss_cnt_o  <= 32'h0;
            stall_cnt_o <= 32'h0;
        end else begin
            if (state_q == IDLE && is_rd && hit) hit_cnt_o <= hit_cnt_o + 32'h1;
            if (state_q == IDLE && state_d == RD_MISS) miss_cnt_o <= miss_cnt_o + 32'h1;
            if (stall_o) stall_cnt_o <= stall_cnt_o + 32'h1;
        end
    end
`endif

endmodule

// File: doc/dmem_stall_ctrl.md
Name: dmem_stall_ctrl

Overview:
- MEM-stage data-memory controller. Consumes the MEM-stage request (MemRead/MemWrite, ALU result as address, RS2 data as write data) held by the EX/MEM pipeline latch.
- Produces the stall signal that freezes that latch and the earlier stages.
- Contains a direct-mapped, write-through, no-write-allocate cache with one 32-bit word per line, backed by a slow external memory over a req/ack handshake.

Parameters:
- INDEX_W, 5, index bits; cache holds 2**INDEX_W lines.
- TAG_W, 25, tag bits; must equal 30-INDEX_W.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- rd_i  in  1  load request (MemRead from EX/MEM).
- wr_i  in  1  store request (MemWrite from EX/MEM).
- addr_i  in  32  byte address; bits [1:0] ignored.
- wdata_i  in  32  store data.
- rdata_o  out  32  load data to MEM/WB.
- stall_o  out  1  pipeline stall, drives EX/MEM stall_i.
- mem_req_o  out  1  external request.
- mem_we_o  out  1  external write enable.
- mem_addr_o  out  32  external word address (bits [1:0] = 0).
- mem_wdata_o  out  32  external write data.
- mem_rdata_i  in  32  external read data, valid with ack.
- mem_ack_i  in  1  external completion, one-cycle pulse.

Behaviour:
- Address split: index = addr_i[INDEX_W+1:2]; tag = addr_i[31:INDEX_W+2].
- Line state: valid bit, tag, data. hit = valid[index] & (tag match).
- Reset (async): FSM=IDLE; all valid bits cleared; mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0; stall_o=0; rdata_o=0.
- A reset asserted mid-transaction abandons it. mem_req_o drops immediately and no line is filled.
- Requests: rd_i and wr_i both high is treated as a write. Inputs are stable while stall_o=1 because the EX/MEM latch is frozen.
- FSM states: IDLE, RD_MISS, WR_MEM, DONE.
- IDLE:
  - rd_i & hit: rdata_o = line data combinationally; stall_o=0; stay in IDLE (zero-wait load).
  - rd_i & miss: stall_o=1 combinationally. Next edge: mem_req_o=1, mem_we_o=0, mem_addr_o={addr_i[31:2],2'b0}; go to RD_MISS.
  - wr_i: stall_o=1 combinationally. Next edge: mem_req_o=1, mem_we_o=1, address as above, mem_wdata_o=wdata_i; go to WR_MEM.
  - Neither: stall_o=0, rdata_o=0.
- RD_MISS:
  - stall_o=1; request signals held stable.
  - On mem_ack_i: write the line (valid=1, tag, mem_rdata_i); capture mem_rdata_i into a fill register; mem_req_o=0 at that edge; go to DONE.
- WR_MEM:
  - stall_o=1; request signals held stable.
  - On mem_ack_i: if hit, update line data with wdata_i (no allocate on miss); mem_req_o=0, mem_we_o=0; go to DONE.
- DONE:
  - Lasts exactly 1 cycle; stall_o=0.
  - rdata_o = fill register after a read, 0 after a write.
  - Next edge: IDLE. The pipeline advances at that edge, so the completed request is never reissued.
- Latency from request to stall release:
  - Load hit: 0 stall cycles.
  - Miss or store: 1 (issue) + N (until ack) stall cycles, then the DONE cycle.
- mem_ack_i while mem_req_o=0 is ignored.
- Back-to-back requests are serviced independently, e.g. a miss followed by a hit to the same line hits.
- Index aliasing: a miss to the same index with a different tag overwrites the line.

Optional Feature:
- Macro DMEM_STATS_EN.
- Defined: adds output ports hit_cnt_o[31:0], miss_cnt_o[31:0], stall_cnt_o[31:0], all reset to 0.
  - hit_cnt_o increments once per IDLE load hit.
  - miss_cnt_o increments once per RD_MISS entry.
  - stall_cnt_o increments every cycle stall_o=1.
  - All counters wrap at 2**32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Cold load: rd_i=1, addr 0x100; memory acks on the 3rd request cycle with 0xDEADBEEF -> stall_o high 4 cycles; mem_addr_o=0x100, mem_we_o=0; DONE cycle has rdata_o=0xDEADBEEF, stall_o=0.
- Load hit: repeat load of 0x100 -> stall_o=0 with rdata_o=0xDEADBEEF the same cycle; no mem_req_o.
- Store hit: wr_i to 0x100 with 0x12345678, ack after 1 cycle -> mem_we_o=1, mem_wdata_o=0x12345678; then load 0x100 hits with 0x12345678.
- Store miss: wr_i to 0x200 (index 0) -> external write occurs; subsequent load of 0x200 misses (no allocate).
- Aliasing: load 0x80 then 0x1080 (same index) -> both miss; a re-load of 0x80 misses again.
- Reset mid-RD_MISS: assert rst_i while mem_req_o=1 -> mem_req_o, stall_o, rdata_o go 0 immediately; a later load of the same address misses.
